// File: rtl/tempdivq_reader.sv
// Streaming read-side controller for the TempdivQ quotient scratch RAM.
// Walks a wrap-around address window and emits words on a registered valid/ready stream.
module tempdivq_reader #(
  parameter int RAM_WIDTH     = 13,
  parameter int RAM_ADDR_BITS = 11
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [RAM_ADDR_BITS-1:0] base_addr,
  input  logic [RAM_ADDR_BITS:0]   length,
  output logic                     busy,
  output logic                     done,
  output logic [RAM_ADDR_BITS-1:0] read_address,
  input  logic [RAM_WIDTH-1:0]     output_data,
  output logic [RAM_WIDTH-1:0]     m_data,
  output logic                     m_valid,
  output logic                     m_last,
  input  logic                     m_ready,
  output logic [1:0]               fsm_state
);

  // Stream handshake: a word moves on any rising edge where m_valid && m_ready.
  // Once raised, m_valid and its m_data/m_last hold until that transfer.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  localparam logic [RAM_ADDR_BITS:0] REM_ONE = 1;

  state_t                   state, state_n;
  logic [RAM_ADDR_BITS-1:0] addr, addr_n;
  logic [RAM_ADDR_BITS:0]   remaining, remaining_n;
  logic [RAM_WIDTH-1:0]     data_n;
  logic                     valid_n;
  logic                     last_n;
  logic                     done_n;
  logic                     xfer;
  logic                     load;

  assign xfer = m_valid && m_ready;
  // The output register may refill on the same edge that drains it.
  assign load = (state == STREAM) && (remaining != '0) && (!m_valid || m_ready);

  assign read_address = addr;
  assign busy         = (state == STREAM) || (state == FLUSH);
  assign fsm_state    = state;

  always_comb begin
    state_n     = state;
    addr_n      = addr;
    remaining_n = remaining;
    data_n      = m_data;
    valid_n     = m_valid;
    last_n      = m_last;
    done_n      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (length == '0) begin
            done_n = 1'b1;
          end else begin
            addr_n      = base_addr;
            remaining_n = length;
            state_n     = STREAM;
          end
        end
      end
      STREAM: begin
        if (load) begin
          data_n      = output_data;
          valid_n     = 1'b1;
          last_n      = (remaining == REM_ONE);
          addr_n      = addr + 1'b1;
          remaining_n = remaining - 1'b1;
          if (remaining == REM_ONE) state_n = FLUSH;
        end else if (xfer) begin
          valid_n = 1'b0;
        end
      end
      FLUSH: begin
        if (xfer) begin
          valid_n = 1'b0;
          last_n  = 1'b0;
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      m_data    <= '0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      addr      <= addr_n;
      remaining <= remaining_n;
      m_data    <= data_n;
      m_valid   <= valid_n;
      m_last    <= last_n;
      done      <= done_n;
    end
  end

endmodule
